exec_control_unit: RTL and testbench
====================================

# exec_control_unit

Execute-stage control block: decodes ALU_OP/FUNC3/FUNC7 into the ALU operation select and sequences multi-cycle M-extension operations (MUL*/DIV*/REM*) with a pipeline stall and an MDU start/kill handshake. It sits between the ID/EX pipeline register and the ALU/MDU datapath. It replaces the purely combinational ALU control decode. Decode width and per-class MDU latencies are parameters.

## Interface
- CTRL_W, 5: ALU_CONTROL width. Must be ≥5. The invalid code is all-ones.
- MUL_LATENCY, 1: cycles from accept to result for MUL/MULH/MULHSU/MULHU. Must be ≥1.
- DIV_LATENCY, 33: cycles from accept to result for DIV/DIVU/REM/REMU. Must be ≥1.
- CLK  in  1  clock. Single clock domain.
- RESET_N  in  1  asynchronous, active-low reset.
- VALID_IN  in  1  the ID/EX stage holds a valid instruction.
- FLUSH  in  1  squash the instruction in EX.
- ALU_OP  in  3  main-decoder class.
- FUNC3  in  3  instruction funct3.
- FUNC7  in  7  instruction funct7.
- ALU_CONTROL  out  CTRL_W  ALU/MDU operation select. Combinational.
- ILLEGAL  out  1  VALID_IN and ALU_CONTROL is all-ones.
- STALL  out  1  hold IF/ID/EX; EX result not ready.
- MDU_START  out  1  one-cycle pulse launching an MDU op.
- MDU_KILL  out  1  abort an in-flight MDU op.
- MDU_RESULT_SEL  out  1  EX writeback takes the MDU result this cycle.

## Operation
- Decode is combinational from ALU_OP/FUNC3/FUNC7 and independent of VALID_IN and state.
- Codes:
  - AND 0, OR 1, ADD 2, SUB 3, SLL 4, SLT 5, SLTU 6, XOR 7, SRL 8, SRA 9.
  - MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
  - FWD 18 (pass immediate). INVALID all-ones.
  - All codes are zero-extended to CTRL_W.
- ALU_OP 0, R-type: full {FUNC3,FUNC7} match. FUNC7=0100000 is legal only with FUNC3 000 (SUB) and 101 (SRA). FUNC7=0000001 selects the M ops. Anything else is INVALID.
- ALU_OP 1 (load), 2 (JALR), 4 (store/branch/jump), 6 (AUIPC) → ADD.
- ALU_OP 3, I-arith:
  - FUNC3 selects ADDI/SLTI/SLTIU/XORI/ORI/ANDI.
  - SLLI requires FUNC7=0. SRLI requires FUNC7=0; SRAI requires FUNC7=0100000. Other FUNC7 values → INVALID.
- ALU_OP 5 (LUI) → FWD. ALU_OP 7 → INVALID.
- Op class: MULC = codes 10–13, with latency MUL_LATENCY; DIVC = codes 14–17, with latency DIV_LATENCY. Let L be the latency of the current class.
- FSM states: IDLE, BUSY.
- IDLE:
  - If VALID_IN & ~FLUSH & class∈{MULC,DIVC}: MDU_START=1 (accept cycle).
  - If L==1: MDU_RESULT_SEL=1, STALL=0, stay in IDLE.
  - Else: STALL=1, load CNT=L-2, go to BUSY.
- BUSY:
  - CNT≠0: STALL=1, CNT decrements.
  - CNT==0: STALL=0, MDU_RESULT_SEL=1, go to IDLE.
- Instruction inputs stay stable while STALL=1 (the pipeline holds). The block does not re-decode the class in BUSY.
- FLUSH priority:
  - In BUSY: MDU_KILL=1, STALL=0, MDU_RESULT_SEL=0, and the next state is IDLE. FLUSH wins over CNT==0.
  - In IDLE: suppresses MDU_START and STALL. MDU_KILL=0.
- Back-to-back: an M op may be accepted in the cycle after BUSY→IDLE.
- Non-M ops never stall.
- CNT width is $clog2(max(MUL_LATENCY,DIV_LATENCY)), minimum 1.

## Timing
- Reset (RESET_N low, async): state=IDLE, CNT=0.
- While RESET_N is low, STALL, MDU_START, MDU_KILL, MDU_RESULT_SEL and ILLEGAL are forced 0 combinationally. ALU_CONTROL = decode of its inputs.
- Reset asserted mid-BUSY: outputs drop immediately. No MDU_KILL is issued; the MDU shares the reset.
- M op with L>1: accept at cycle 0, STALL high in cycles 0..L-2, MDU_RESULT_SEL in cycle L-1.
- M op with L==1: MDU_START and MDU_RESULT_SEL both assert in cycle 0.
- All control outputs are combinational from state and inputs. State updates on the rising edge of CLK.

## Configuration
- EXEC_CTRL_MDU_EN defined: M-op decode, FSM and MDU outputs exist as specified.
- EXEC_CTRL_MDU_EN undefined:
  - FUNC7=0000001 R-type decodes to INVALID, so ILLEGAL is asserted.
  - STALL, MDU_START, MDU_KILL and MDU_RESULT_SEL are tied 0. No FSM/CNT flops.

## Structure
- Shared package exec_ctrl_pkg holds:
  - ALU_OP class localparams (R, LOAD, JALR, IARITH, SBJ, LUI, AUIPC).
  - ALU_CONTROL code localparams (5-bit base values).
  - The FSM state enum.
- One sub-module, alu_op_decoder: combinational decode producing ALU_CONTROL plus is_mul/is_div flags. The FSM and counter live in the top.

## Test plan
- Full decode sweep with VALID_IN=1: every legal ALU_OP/FUNC3/FUNC7 combination → the listed code. ALU_OP=0, FUNC3=000, FUNC7=0100001 → all-ones and ILLEGAL=1. STALL stays 0 for non-M ops.
- DIV_LATENCY=33, DIV held for 33 cycles:
  - MDU_START in cycle 0 only.
  - STALL high in cycles 0–31.
  - MDU_RESULT_SEL and STALL=0 in cycle 32.
- MUL_LATENCY=1: MUL, then ADD on the next cycle → no STALL. MDU_START and MDU_RESULT_SEL in the same cycle.
- FLUSH in cycle 5 of a DIV → MDU_KILL=1 and STALL=0 that cycle, IDLE next. A new DIV two cycles later restarts the full 33-cycle sequence.
- RESET_N pulled low in cycle 10 of a DIV → all control outputs 0 immediately. After release, an ADD is decoded as 2 with no stall.
- Build without EXEC_CTRL_MDU_EN: a MUL instruction → ALU_CONTROL all-ones, ILLEGAL=1, STALL=0, MDU_START=0.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared ALU_OP classes, ALU_CONTROL base codes and the MDU sequencer state.
package exec_ctrl_pkg;

  localparam logic [2:0] OP_R      = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_JALR   = 3'd2;
  localparam logic [2:0] OP_IARITH = 3'd3;
  localparam logic [2:0] OP_SBJ    = 3'd4;
  localparam logic [2:0] OP_LUI    = 3'd5;
  localparam logic [2:0] OP_AUIPC  = 3'd6;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] C_AND    = 5'd0;
  localparam logic [4:0] C_OR     = 5'd1;
  localparam logic [4:0] C_ADD    = 5'd2;
  localparam logic [4:0] C_SUB    = 5'd3;
  localparam logic [4:0] C_SLL    = 5'd4;
  localparam logic [4:0] C_SLT    = 5'd5;
  localparam logic [4:0] C_SLTU   = 5'd6;
  localparam logic [4:0] C_XOR    = 5'd7;
  localparam logic [4:0] C_SRL    = 5'd8;
  localparam logic [4:0] C_SRA    = 5'd9;
  localparam logic [4:0] C_MUL    = 5'd10;
  localparam logic [4:0] C_MULH   = 5'd11;
  localparam logic [4:0] C_MULHSU = 5'd12;
  localparam logic [4:0] C_MULHU  = 5'd13;
  localparam logic [4:0] C_DIV    = 5'd14;
  localparam logic [4:0] C_DIVU   = 5'd15;
  localparam logic [4:0] C_REM    = 5'd16;
  localparam logic [4:0] C_REMU   = 5'd17;
  localparam logic [4:0] C_FWD    = 5'd18;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU_OP/FUNC3/FUNC7 decode into the ALU/MDU select and class flags.
// M-extension codes are only produced when EXEC_CTRL_MDU_EN is defined.
module alu_op_decoder
  import exec_ctrl_pkg::*;
#(
  parameter int CTRL_W = 5
) (
  input  logic [2:0]        alu_op,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  output logic [CTRL_W-1:0] alu_control,
  output logic              is_mul,
  output logic              is_div
);

  logic [4:0] code;
  logic       invalid;

  always_comb begin
    code    = C_ADD;
    invalid = 1'b0;
    case (alu_op)
      OP_R: begin
        if (func7 == F7_BASE) begin
          case (func3)
            3'b000:  code = C_ADD;
            3'b001:  code = C_SLL;
            3'b010:  code = C_SLT;
            3'b011:  code = C_SLTU;
            3'b100:  code = C_XOR;
            3'b101:  code = C_SRL;
            3'b110:  code = C_OR;
            default: code = C_AND;
          endcase
        end else if (func7 == F7_ALT && func3 == 3'b000) begin
          code = C_SUB;
        end else if (func7 == F7_ALT && func3 == 3'b101) begin
          code = C_SRA;
`ifdef EXEC_CTRL_MDU_EN
        end else if (func7 == F7_MULDIV) begin
          case (func3)
            3'b000:  code = C_MUL;
            3'b001:  code = C_MULH;
            3'b010:  code = C_MULHSU;
            3'b011:  code = C_MULHU;
            3'b100:  code = C_DIV;
            3'b101:  code = C_DIVU;
            3'b110:  code = C_REM;
            default: code = C_REMU;
          endcase
`endif
        end else begin
          invalid = 1'b1;
        end
      end
      OP_LOAD, OP_JALR, OP_SBJ, OP_AUIPC: code = C_ADD;
      OP_IARITH: begin
        case (func3)
          3'b000: code = C_ADD;
          3'b010: code = C_SLT;
          3'b011: code = C_SLTU;
          3'b100: code = C_XOR;
          3'b110: code = C_OR;
          3'b111: code = C_AND;
          3'b001: begin
            if (func7 == F7_BASE) code = C_SLL;
            else                  invalid = 1'b1;
          end
          default: begin
            // shift-right immediates: funct7 picks logical vs arithmetic
            if (func7 == F7_BASE)     code = C_SRL;
            else if (func7 == F7_ALT) code = C_SRA;
            else                      invalid = 1'b1;
          end
        endcase
      end
      OP_LUI:  code = C_FWD;
      default: invalid = 1'b1;
    endcase
  end

  assign alu_control = invalid ? '1 : CTRL_W'(code);
  assign is_mul      = !invalid && (code >= C_MUL) && (code <= C_MULHU);
  assign is_div      = !invalid && (code >= C_DIV) && (code <= C_REMU);

endmodule

// File: rtl/exec_control_unit.sv
// Execute-stage control: ALU decode plus MDU start/stall/kill sequencing.
// EXEC_CTRL_MDU_EN enables M-op decode and the MDU sequencer; otherwise MDU outputs tie to 0.
module exec_control_unit
  import exec_ctrl_pkg::*;
#(
  parameter int CTRL_W      = 5,
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 33
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VALID_IN,
  input  logic              FLUSH,
  input  logic [2:0]        ALU_OP,
  input  logic [2:0]        FUNC3,
  input  logic [6:0]        FUNC7,
  output logic [CTRL_W-1:0] ALU_CONTROL,
  output logic              ILLEGAL,
  output logic              STALL,
  output logic              MDU_START,
  output logic              MDU_KILL,
  output logic              MDU_RESULT_SEL
);

  logic is_mul, is_div;

  alu_op_decoder #(.CTRL_W(CTRL_W)) u_dec (
    .alu_op      (ALU_OP),
    .func3       (FUNC3),
    .func7       (FUNC7),
    .alu_control (ALU_CONTROL),
    .is_mul      (is_mul),
    .is_div      (is_div)
  );

  assign ILLEGAL = RESET_N & VALID_IN & (&ALU_CONTROL);

`ifdef EXEC_CTRL_MDU_EN
  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  // BUSY covers cycles 1..L-1, so the counter starts at L-2
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_LATENCY > 1) ? CNT_W'(DIV_LATENCY - 2) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, single;

  assign accept = VALID_IN & ~FLUSH & (is_mul | is_div);
  assign single = is_mul ? (MUL_LATENCY == 1) : (DIV_LATENCY == 1);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    STALL          = 1'b0;
    MDU_START      = 1'b0;
    MDU_KILL       = 1'b0;
    MDU_RESULT_SEL = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          MDU_START = 1'b1;
          if (single) begin
            MDU_RESULT_SEL = 1'b1;
          end else begin
            STALL     = 1'b1;
            cnt_nxt   = is_mul ? MUL_LOAD : DIV_LOAD;
            state_nxt = ST_BUSY;
          end
        end
      end
      default: begin
        if (FLUSH) begin
          MDU_KILL  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt != '0) begin
          STALL   = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          MDU_RESULT_SEL = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end
    endcase
    // the MDU shares our reset, so nothing is killed; just go quiet
    if (!RESET_N) begin
      STALL          = 1'b0;
      MDU_START      = 1'b0;
      MDU_KILL       = 1'b0;
      MDU_RESULT_SEL = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{CLK, FLUSH, is_mul, is_div, (MUL_LATENCY == DIV_LATENCY)};

  assign STALL          = 1'b0;
  assign MDU_START      = 1'b0;
  assign MDU_KILL       = 1'b0;
  assign MDU_RESULT_SEL = 1'b0;
`endif

endmodule

// File: tb/tb_exec_control_unit.sv
// Randomized + directed bench for exec_control_unit against a transaction-level reference model.
module tb_exec_control_unit;

  localparam int CW = 5;
  localparam int ML = 1;
  localparam int DL = 33;
`ifdef EXEC_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          VALID_IN = 1'b0;
  logic          FLUSH = 1'b0;
  logic [2:0]    ALU_OP = '0;
  logic [2:0]    FUNC3 = '0;
  logic [6:0]    FUNC7 = '0;
  logic [CW-1:0] ALU_CONTROL;
  logic          ILLEGAL, STALL, MDU_START, MDU_KILL, MDU_RESULT_SEL;

  int checks = 0;
  int failures = 0;

  // reference model: is an M op outstanding, and how many cycles until its result cycle
  bit m_busy = 1'b0;
  int m_left = 0;
  // snapshots of the last sampled cycle
  logic [CW-1:0] o_ctrl;
  logic o_stall, o_start, o_kill, o_rsel, o_ill;
  logic [2:0] l_op, l_f3;
  logic [6:0] l_f7;

  int r_tab[8] = '{2, 4, 5, 6, 7, 8, 1, 0};

  always #5 CLK = ~CLK;

  exec_control_unit #(.CTRL_W(CW), .MUL_LATENCY(ML), .DIV_LATENCY(DL)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .VALID_IN(VALID_IN), .FLUSH(FLUSH),
    .ALU_OP(ALU_OP), .FUNC3(FUNC3), .FUNC7(FUNC7),
    .ALU_CONTROL(ALU_CONTROL), .ILLEGAL(ILLEGAL), .STALL(STALL),
    .MDU_START(MDU_START), .MDU_KILL(MDU_KILL), .MDU_RESULT_SEL(MDU_RESULT_SEL)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // -1 means INVALID
  function automatic int ref_code(input int op, input int f3, input int f7);
    case (op)
      0: begin
        if (f7 == 0) return r_tab[f3];
        if (f7 == 'h20) return (f3 == 0) ? 3 : (f3 == 5) ? 9 : -1;
        if (f7 == 1) return MDU_EN ? 10 + f3 : -1;
        return -1;
      end
      1, 2, 4, 6: return 2;
      3: begin
        if (f3 == 1) return (f7 == 0) ? 4 : -1;
        if (f3 == 5) return (f7 == 0) ? 8 : (f7 == 'h20) ? 9 : -1;
        return r_tab[f3];
      end
      5: return 18;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_lat(input int code);
    if (code >= 10 && code <= 13) return ML;
    if (code >= 14 && code <= 17) return DL;
    return 0;
  endfunction

  // one clock cycle: drive, check at negedge, advance the model at posedge
  task automatic cyc(input bit rst, input bit v, input bit fl,
                     input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    int code, lat, nleft;
    bit es, est, ek, er, nbusy;
    RESET_N = rst; VALID_IN = v; FLUSH = fl; ALU_OP = op; FUNC3 = f3; FUNC7 = f7;
    l_op = op; l_f3 = f3; l_f7 = f7;
    @(negedge CLK);
    code = ref_code(op, f3, f7);
    lat  = ref_lat(code);
    es = 0; est = 0; ek = 0; er = 0; nbusy = m_busy; nleft = m_left;
    if (rst && MDU_EN) begin
      if (m_busy) begin
        if (fl)               begin ek = 1; nbusy = 0; end
        else if (m_left == 1) begin er = 1; nbusy = 0; end
        else                  begin es = 1; nleft = m_left - 1; end
      end else if (v && !fl && lat > 0) begin
        est = 1;
        if (lat == 1) er = 1;
        else begin es = 1; nbusy = 1; nleft = lat - 1; end
      end
    end
    o_ctrl = ALU_CONTROL; o_stall = STALL; o_start = MDU_START;
    o_kill = MDU_KILL; o_rsel = MDU_RESULT_SEL; o_ill = ILLEGAL;
    chk("alu_control", 32'(ALU_CONTROL), (code < 0) ? 32'(CW'('1)) : 32'(code));
    chk("illegal", 32'(ILLEGAL), 32'(rst && v && code < 0));
    chk("stall", 32'(STALL), 32'(es));
    chk("mdu_start", 32'(MDU_START), 32'(est));
    chk("mdu_kill", 32'(MDU_KILL), 32'(ek));
    chk("mdu_result_sel", 32'(MDU_RESULT_SEL), 32'(er));
    @(posedge CLK);
    if (rst) begin m_busy = nbusy; m_left = nleft; end
    else begin m_busy = 0; m_left = 0; end
    #1;
  endtask

  // issue an instruction and hold it while the model says the pipe is stalled
  task automatic issue(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cyc(1, 1, 0, op, f3, f7);
    while (m_busy) cyc(1, 1, 0, op, f3, f7);
  endtask

  task automatic div_run(input string tag);
    for (int k = 0; k < DL; k++) begin
      cyc(1, 1, 0, 3'd0, 3'b100, 7'h01);
      chk({tag, "_start"}, 32'(o_start), 32'(MDU_EN && k == 0));
      chk({tag, "_stall"}, 32'(o_stall), 32'(MDU_EN && k <= DL - 2));
      chk({tag, "_rsel"},  32'(o_rsel),  32'(MDU_EN && k == DL - 1));
    end
  endtask

  function automatic logic [6:0] rnd_f7();
    case ($urandom_range(0, 4))
      0, 1:    return 7'h00;
      2:       return 7'h20;
      3:       return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [6:0] f7_list[5];
    @(posedge CLK); #1;

    // reset: MDU outputs and ILLEGAL forced low, decode still live
    cyc(0, 1, 0, 3'd0, 3'b100, 7'h01);
    chk("rst_stall", 32'(o_stall), 32'd0);
    cyc(0, 1, 0, 3'd7, 3'b000, 7'h00);
    chk("rst_illegal", 32'(o_ill), 32'd0);
    cyc(0, 1, 0, 3'd0, 3'b000, 7'h00);
    chk("rst_add", 32'(o_ctrl), 32'd2);

    // full decode sweep
    f7_list = '{7'h00, 7'h20, 7'h01, 7'h21, 7'h7f};
    for (int op = 0; op < 8; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int j = 0; j < 5; j++)
          issue(3'(op), 3'(f3), f7_list[j]);
    cyc(1, 1, 0, 3'd0, 3'b000, 7'h21);
    chk("r_f7_21_ctrl", 32'(o_ctrl), 32'(CW'('1)));
    chk("r_f7_21_ill", 32'(o_ill), 32'd1);

    // DIV full latency
    div_run("div");

    // MUL then ADD, single-cycle MUL
    cyc(1, 1, 0, 3'd0, 3'b000, 7'h01);
    chk("mul_start", 32'(o_start), 32'(MDU_EN));
    chk("mul_rsel", 32'(o_rsel), 32'(MDU_EN));
    chk("mul_ctrl", 32'(o_ctrl), MDU_EN ? 32'd10 : 32'(CW'('1)));
    chk("mul_ill", 32'(o_ill), 32'(!MDU_EN));
    cyc(1, 1, 0, 3'd0, 3'b000, 7'h00);
    chk("add_after_mul_stall", 32'(o_stall), 32'd0);

    // FLUSH in cycle 5 of DIV, then a fresh DIV two cycles later
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 3'd0, 3'b100, 7'h01);
    cyc(1, 1, 1, 3'd0, 3'b100, 7'h01);
    chk("flush_kill", 32'(o_kill), 32'(MDU_EN));
    chk("flush_stall", 32'(o_stall), 32'd0);
    cyc(1, 0, 0, 3'd0, 3'b000, 7'h00);
    div_run("div_after_flush");

    // reset in cycle 10 of DIV
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 3'd0, 3'b100, 7'h01);
    cyc(0, 1, 0, 3'd0, 3'b100, 7'h01);
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_kill", 32'(o_kill), 32'd0);
    cyc(1, 1, 0, 3'd0, 3'b000, 7'h00);
    chk("postrst_add", 32'(o_ctrl), 32'd2);
    chk("postrst_stall", 32'(o_stall), 32'd0);

    // randomized traffic; hold the instruction while stalled
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0)
        cyc(0, 1'($urandom), 0, 3'($urandom), 3'($urandom), rnd_f7());
      else if (m_busy)
        cyc(1, 1, ($urandom_range(0, 29) == 0), l_op, l_f3, l_f7);
      else
        cyc(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            3'($urandom_range(0, 7)), 3'($urandom), rnd_f7());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
